// File: rtl/imem_boot_ctrl.sv
// Instruction-memory boot loader and fetch gate.
// Receives a length-prefixed little-endian byte stream, writes the assembled
// words into IMEM, then releases the core and serves fetches from IMEM,
// substituting NOP for anything outside the loaded image.
module imem_boot_ctrl #(
  parameter int          ADDR_W = 8,
  parameter logic [31:0] NOP    = 32'h00000013
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              boot_req,
  input  logic [31:0]       fetch_addr,
  output logic [31:0]       fetch_instr,
  output logic              core_hold,
  output logic [ADDR_W-1:0] imem_raddr,
  input  logic [31:0]       imem_rdata,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              load_done,
  output logic [15:0]       words_loaded,
  output logic              overflow
);

  typedef enum logic [2:0] {
    HDR0,
    HDR1,
    DATA,
    FLUSH,
    RUN
  } state_t;

  // Number of IMEM words; one bit wider than any word index it is compared with.
  localparam logic [32:0] DEPTH = 33'd1 << ADDR_W;

  state_t      state;
  state_t      state_next;

  logic [7:0]  n_lo;
  logic [15:0] n_hdr;
  logic [1:0]  byte_cnt;
  logic [23:0] byte_buf;
  logic [15:0] word_idx;
  logic        word_done;
  logic        last_word;
  logic        word_in_range;
  logic        fetch_upper_hit;
  logic        fetch_beyond_image;
  logic [31:0] fetch_idx;

  // Full header value as it stands on the byte that completes it.
  assign n_hdr = {rx_data, n_lo};

  // The 4th byte of a word is on the bus; in DATA rx_ready is always high.
  assign word_done = (state == DATA) && rx_valid && (byte_cnt == 2'd3);

  // DATA is only entered with a non-zero count, so N-1 never wraps.
  assign last_word = (word_idx == (words_loaded - 16'd1));

  // Words past the end of IMEM are swallowed and flagged instead of written.
  assign word_in_range = ({17'd0, word_idx} < DEPTH);

  // Next-state and handshake/hold decode.
  always_comb begin
    state_next = state;
    rx_ready   = 1'b0;
    core_hold  = 1'b1;
    case (state)
      HDR0: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          state_next = HDR1;
        end
      end
      HDR1: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          state_next = (n_hdr != 16'd0) ? DATA : RUN;
        end
      end
      DATA: begin
        rx_ready = 1'b1;
        if (word_done && last_word) begin
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        state_next = RUN;
      end
      RUN: begin
        core_hold = 1'b0;
        if (boot_req) begin
          state_next = HDR0;
        end
      end
      default: begin
        state_next = HDR0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= HDR0;
    end else begin
      state <= state_next;
    end
  end

  // Header capture, image status and the reload clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      n_lo         <= 8'd0;
      words_loaded <= 16'd0;
      overflow     <= 1'b0;
    end else begin
      if ((state == HDR0) && rx_valid) begin
        n_lo <= rx_data;
      end
      if ((state == HDR1) && rx_valid) begin
        words_loaded <= n_hdr;
      end
      if (word_done && !word_in_range) begin
        overflow <= 1'b1;
      end
      if ((state == RUN) && boot_req) begin
        n_lo         <= 8'd0;
        words_loaded <= 16'd0;
        overflow     <= 1'b0;
      end
    end
  end

  // Byte assembler: bytes shift in from the top so b0 ends up in the low byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt <= 2'd0;
      byte_buf <= 24'd0;
      word_idx <= 16'd0;
    end else begin
      if ((state == DATA) && rx_valid) begin
        if (byte_cnt == 2'd3) begin
          byte_cnt <= 2'd0;
          word_idx <= word_idx + 16'd1;
        end else begin
          byte_cnt <= byte_cnt + 2'd1;
          byte_buf <= {rx_data, byte_buf[23:8]};
        end
      end
      if ((state == RUN) && boot_req) begin
        byte_cnt <= 2'd0;
        word_idx <= 16'd0;
      end
    end
  end

  // Registered IMEM write port: one strobe the cycle after a word completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= 32'd0;
    end else begin
      imem_we <= 1'b0;
      if (word_done && word_in_range) begin
        imem_we    <= 1'b1;
        imem_waddr <= ADDR_W'(word_idx);
        imem_wdata <= {rx_data, byte_buf};
      end
    end
  end

  // load_done marks the first RUN cycle, from either FLUSH or an empty header.
  always_ff @(posedge clk) begin
    if (reset) begin
      load_done <= 1'b0;
    end else begin
      load_done <= ((state == FLUSH) ||
                    ((state == HDR1) && rx_valid && (n_hdr == 16'd0)));
    end
  end

  // Fetch gating: low two address bits are ignored, anything outside the image is NOP.
  assign imem_raddr = fetch_addr[ADDR_W+1:2];

  // Out-of-range decode for the fetch path.
  always_comb begin
    fetch_idx          = 32'(imem_raddr);
    fetch_upper_hit    = ((fetch_addr >> (ADDR_W + 2)) != 32'd0);
    fetch_beyond_image = (fetch_idx >= 32'(words_loaded));
  end

  assign fetch_instr = (core_hold || fetch_upper_hit || fetch_beyond_image) ? NOP : imem_rdata;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Randomized self-checking bench for imem_boot_ctrl.
// The bench owns a small IMEM array and a reference image built from the
// byte stream it sends; expected writes and fetches come from that image.
module tb_imem_boot_ctrl;

  localparam int          ADDR_W = 4;
  localparam int          DEPTH  = 16;
  localparam logic [31:0] NOP    = 32'h00000013;

  logic              clk = 1'b0;
  logic              reset;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              boot_req;
  logic [31:0]       fetch_addr;
  logic [31:0]       fetch_instr;
  logic              core_hold;
  logic [ADDR_W-1:0] imem_raddr;
  logic [31:0]       imem_rdata;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              load_done;
  logic [15:0]       words_loaded;
  logic              overflow;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem     [DEPTH];
  logic [31:0] img_src [64];
  logic [31:0] ref_img [DEPTH];
  int          ref_n;
  logic [7:0]  stream  [$];

  imem_boot_ctrl #(.ADDR_W(ADDR_W), .NOP(NOP)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .boot_req     (boot_req),
    .fetch_addr   (fetch_addr),
    .fetch_instr  (fetch_instr),
    .core_hold    (core_hold),
    .imem_raddr   (imem_raddr),
    .imem_rdata   (imem_rdata),
    .imem_we      (imem_we),
    .imem_waddr   (imem_waddr),
    .imem_wdata   (imem_wdata),
    .load_done    (load_done),
    .words_loaded (words_loaded),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  // Behavioural IMEM: asynchronous read, write on the rising edge.
  always @(posedge clk) begin
    if (imem_we) mem[imem_waddr] <= imem_wdata;
  end
  assign imem_rdata = mem[imem_raddr];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends header plus image words from img_src; mode 0 = no bubbles,
  // 1 = valid toggles every cycle, 2 = random bubbles. A reset is pulsed
  // once abort_after bytes have been accepted.
  task automatic applyStimulus(input int n, input int mode, input int abort_after);
    int   sent;
    int   cyc;
    int   k;
    logic valid;
    logic exp_we;
    logic [31:0] w;
    stream.delete();
    stream.push_back(n[7:0]);
    stream.push_back(n[15:8]);
    for (int i = 0; i < n; i++) begin
      w = img_src[i];
      stream.push_back(w[7:0]);
      stream.push_back(w[15:8]);
      stream.push_back(w[23:16]);
      stream.push_back(w[31:24]);
    end
    sent = 0;
    cyc  = 0;
    while (sent < stream.size()) begin
      if (sent == abort_after) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("abort_hold", core_hold, 1);
        checkOutput("abort_ready", rx_ready, 1);
        checkOutput("abort_we", imem_we, 0);
        checkOutput("abort_words", words_loaded, 0);
        checkOutput("abort_overflow", overflow, 0);
        checkOutput("abort_done", load_done, 0);
        ref_n = 0;
        return;
      end
      checkOutput("load_ready", rx_ready, 1);
      checkOutput("load_hold", core_hold, 1);
      checkOutput("load_fetch_nop", fetch_instr, NOP);
      case (mode)
        0:       valid = 1'b1;
        1:       valid = ((cyc % 2) == 0);
        default: valid = ($urandom_range(99) >= 30);
      endcase
      cyc++;
      rx_valid   = valid;
      rx_data    = valid ? stream[sent] : 8'($urandom);
      boot_req   = 1'($urandom);
      fetch_addr = $urandom_range(0, 63);
      tick();
      rx_valid = 1'b0;
      boot_req = 1'b0;
      exp_we   = 1'b0;
      k        = 0;
      if (valid) begin
        sent++;
        if (sent > 2 && ((sent - 2) % 4) == 0) begin
          k = (sent - 2) / 4 - 1;
          if (k < DEPTH) begin
            exp_we     = 1'b1;
            ref_img[k] = img_src[k];
          end
        end
      end
      checkOutput("imem_we", imem_we, exp_we);
      if (exp_we) begin
        checkOutput("imem_waddr", imem_waddr, k);
        checkOutput("imem_wdata", imem_wdata, img_src[k]);
      end
    end
    if (n != 0) begin
      checkOutput("flush_ready", rx_ready, 0);
      checkOutput("flush_hold", core_hold, 1);
      checkOutput("flush_done", load_done, 0);
      rx_valid = 1'b1;
      rx_data  = 8'($urandom);
      tick();
      rx_valid = 1'b0;
      checkOutput("run_we", imem_we, 0);
    end
    ref_n = n;
    checkOutput("run_done_pulse", load_done, 1);
    checkOutput("run_hold", core_hold, 0);
    checkOutput("run_ready", rx_ready, 0);
    checkOutput("run_words", words_loaded, n);
    checkOutput("run_overflow", overflow, 32'(n > DEPTH));
    rx_valid = 1'b1;
    rx_data  = 8'($urandom);
    tick();
    rx_valid = 1'b0;
    checkOutput("done_one_cycle", load_done, 0);
    checkOutput("run_hold_stays", core_hold, 0);
    checkOutput("run_words_stays", words_loaded, n);
  endtask

  task automatic checkFetch(input logic [31:0] addr);
    int          idx;
    logic [31:0] exp;
    fetch_addr = addr;
    tick();
    idx = int'((addr >> 2) & (DEPTH - 1));
    if (((addr >> (ADDR_W + 2)) != 0) || (idx >= ref_n)) exp = NOP;
    else exp = ref_img[idx];
    checkOutput("fetch_instr", fetch_instr, exp);
    checkOutput("imem_raddr", imem_raddr, idx);
  endtask

  task automatic randomFetches(input int count);
    for (int i = 0; i < count; i++) begin
      if ($urandom_range(3) == 0) checkFetch($urandom);
      else checkFetch($urandom_range(0, 4 * DEPTH + 7));
    end
  endtask

  task automatic requestBoot();
    boot_req = 1'b1;
    tick();
    boot_req = 1'b0;
    ref_n = 0;
    checkOutput("boot_hold", core_hold, 1);
    checkOutput("boot_ready", rx_ready, 1);
    checkOutput("boot_overflow", overflow, 0);
    checkOutput("boot_words", words_loaded, 0);
    checkOutput("boot_fetch_nop", fetch_instr, NOP);
  endtask

  task automatic fillRandom(input int n);
    for (int i = 0; i < n; i++) img_src[i] = $urandom;
  endtask

  // Watchdog so a stuck run still ends with a report.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Test sequence.
  initial begin
    reset      = 1'b1;
    rx_valid   = 1'b0;
    rx_data    = 8'd0;
    boot_req   = 1'b0;
    fetch_addr = 32'd0;
    ref_n      = 0;
    tick();
    tick();
    reset = 1'b0;
    checkOutput("reset_hold", core_hold, 1);
    checkOutput("reset_ready", rx_ready, 1);
    checkOutput("reset_we", imem_we, 0);
    checkOutput("reset_done", load_done, 0);
    checkOutput("reset_words", words_loaded, 0);
    checkOutput("reset_overflow", overflow, 0);
    checkOutput("reset_fetch_nop", fetch_instr, NOP);

    $display("[TB] two-word image");
    img_src[0] = 32'h00100513;
    img_src[1] = 32'h00200593;
    applyStimulus(2, 0, -1);
    checkFetch(32'h4);
    checkFetch(32'h8);
    checkFetch(32'h400);
    checkFetch(32'h3);
    checkOutput("t2_word1", fetch_instr, 32'h00100513);

    $display("[TB] empty image");
    requestBoot();
    applyStimulus(0, 0, -1);
    for (int i = 0; i < 6; i++) checkFetch(32'(4 * i));

    $display("[TB] overflowing image");
    requestBoot();
    fillRandom(20);
    applyStimulus(20, 2, -1);
    randomFetches(12);

    $display("[TB] full image with toggling valid");
    requestBoot();
    fillRandom(DEPTH);
    applyStimulus(DEPTH, 1, -1);
    randomFetches(12);

    $display("[TB] reset mid-load then reload");
    requestBoot();
    fillRandom(5);
    applyStimulus(5, 2, 8);
    fillRandom(7);
    applyStimulus(7, 0, -1);
    randomFetches(12);

    $display("[TB] random images");
    for (int r = 0; r < 6; r++) begin
      int n;
      int mode;
      n    = $urandom_range(1, 20);
      mode = $urandom_range(0, 2);
      requestBoot();
      fillRandom(n);
      applyStimulus(n, mode, -1);
      randomFetches(10);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
